// File: rtl/v74x148_registered.sv
// ---------------------------------------------------------------------------
// v74x148_registered
//
// Registered 8-line priority encoder in the spirit of the 74x148, with sticky
// request capture and an acknowledge that retires the reported request.
//
// Requests on I_L (active-low) are OR-ed into an 8-bit pending register PEND
// each clock while the registered enable EN is set. The outputs decode only
// PEND and EN, so every input reaches the outputs exactly one edge after it
// is sampled. ACK clears the bit currently reported on A_L. A new request on
// the same line at the same edge wins over the clear.
//
// Ports
//   CLK   in   1  single clock, all state changes on the rising edge
//   RST_L in   1  asynchronous active-low reset (clears PEND and EN)
//   EI_L  in   1  enable input, active-low, registered into EN
//   I_L   in   8  request lines, active-low, bit 7 highest priority
//   ACK   in   1  active-high acknowledge of the request shown on A_L
//   A_L   out  3  active-low index of the highest pending request
//   GS_L  out  1  active-low: enabled and at least one request pending
//   EO_L  out  1  active-low: enabled and nothing pending (cascade enable)
// ---------------------------------------------------------------------------
module v74x148_registered (
    input  logic       CLK,
    input  logic       RST_L,
    input  logic       EI_L,
    input  logic [7:0] I_L,
    input  logic       ACK,
    output logic [2:0] A_L,
    output logic       GS_L,
    output logic       EO_L
);

    logic [7:0] pend_q;
    logic [7:0] pend_d;
    logic       en_q;
    logic       en_d;

    // Highest set bit of PEND and whether anything is pending.
    logic [2:0] top_idx;
    logic       any_pend;

    // Acknowledge handling.
    logic       ack_take;
    logic [7:0] ack_mask;

    // -----------------------------------------------------------------------
    // Priority encode of the pending register: bit 7 wins.
    // -----------------------------------------------------------------------
    always_comb begin
        top_idx  = 3'd0;
        any_pend = 1'b1;
        casez (pend_q)
            8'b1???????: top_idx = 3'd7;
            8'b01??????: top_idx = 3'd6;
            8'b001?????: top_idx = 3'd5;
            8'b0001????: top_idx = 3'd4;
            8'b00001???: top_idx = 3'd3;
            8'b000001??: top_idx = 3'd2;
            8'b0000001?: top_idx = 3'd1;
            8'b00000001: top_idx = 3'd0;
            default: begin
                top_idx  = 3'd0;
                any_pend = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode: a function of PEND and EN only. GS_L and EO_L can never
    // both be low because one requires any_pend and the other its inverse.
    // -----------------------------------------------------------------------
    always_comb begin
        A_L  = 3'b111;
        GS_L = 1'b1;
        EO_L = 1'b1;
        if (en_q) begin
            if (any_pend) begin
                A_L  = ~top_idx;
                GS_L = 1'b0;
            end else begin
                EO_L = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    // An acknowledge counts only while the block is enabled and something is
    // being reported (GS_L low); it clears the reported bit. New requests are
    // OR-ed in after the clear so a simultaneous request on the same line
    // keeps it pending.
    // -----------------------------------------------------------------------
    always_comb begin
        ack_take = ACK & en_q & any_pend;
        ack_mask = 8'h00;
        if (ack_take) begin
            ack_mask = 8'h01 << top_idx;
        end

        en_d   = ~EI_L;
        pend_d = pend_q;
        if (en_q) begin
            pend_d = (pend_q & ~ack_mask) | ~I_L;
        end
    end

    // -----------------------------------------------------------------------
    // State registers. EN loads on the first edge after reset release, while
    // PEND is still held by the old EN value, so nothing is captured then.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            pend_q <= 8'h00;
            en_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
        end
    end

endmodule

// File: tb/tb_v74x148_registered.sv
module tb_v74x148_registered;

  logic       CLK;
  logic       RST_L;
  logic       EI_L;
  logic [7:0] I_L;
  logic       ACK;
  logic [2:0] A_L;
  logic       GS_L;
  logic       EO_L;

  int n_compared;
  int n_mismatched;

  // expected {A_L, GS_L, EO_L}
  logic [4:0] exp_q[$];

  typedef struct {
    logic       ei_l;
    logic [7:0] i_l;
    logic       ack;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[16];

  // bench model state for the random phase
  logic [7:0] m_pend;
  logic       m_en;

  v74x148_registered dut (
    .CLK  (CLK),
    .RST_L(RST_L),
    .EI_L (EI_L),
    .I_L  (I_L),
    .ACK  (ACK),
    .A_L  (A_L),
    .GS_L (GS_L),
    .EO_L (EO_L)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    n_mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_now(input logic [4:0] exp, input string name);
    logic [4:0] act;
    act = {A_L, GS_L, EO_L};
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got A_L=%b GS_L=%b EO_L=%b, required A_L=%b GS_L=%b EO_L=%b",
               name, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive inputs (called after a falling edge), push the expectation, let one
  // rising edge pass, then pop and compare; returns after the next falling edge.
  task automatic step(input logic ei, input logic [7:0] i, input logic ack,
                      input logic [4:0] exp, input string name);
    logic [4:0] e;
    EI_L = ei;
    I_L  = i;
    ACK  = ack;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: scoreboard queue empty, got 0 entries, required 1", name);
    end else begin
      e = exp_q.pop_front();
      check_now(e, name);
    end
    @(negedge CLK);
  endtask

  // Independent bench model: scan upward, last set bit is the highest.
  function automatic logic [4:0] model_out(input logic [7:0] p, input logic en);
    logic [2:0] idx;
    logic       any;
    idx = 3'd0;
    any = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (p[b]) begin
        idx = b[2:0];
        any = 1'b1;
      end
    end
    if (!en)       return 5'b111_1_1;
    else if (any)  return {~idx, 1'b0, 1'b1};
    else           return 5'b111_1_0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    //        ei_l  i_l           ack   {A_L,GS_L,EO_L}  name
    vecs[0]  = '{1'b0, 8'hFF,       1'b0, 5'b111_1_0, "idle_edge1"};
    vecs[1]  = '{1'b0, 8'hFF,       1'b0, 5'b111_1_0, "idle_edge2"};
    vecs[2]  = '{1'b0, 8'hFF,       1'b0, 5'b111_1_0, "idle_edge3"};
    vecs[3]  = '{1'b0, 8'b10111011, 1'b0, 5'b001_0_1, "pulse_6_2"};
    vecs[4]  = '{1'b0, 8'hFF,       1'b1, 5'b101_0_1, "ack_line6"};
    vecs[5]  = '{1'b0, 8'hFF,       1'b1, 5'b111_1_0, "ack_line2"};
    vecs[6]  = '{1'b0, 8'hFF,       1'b1, 5'b111_1_0, "ack_empty1"};
    vecs[7]  = '{1'b0, 8'hFF,       1'b1, 5'b111_1_0, "ack_empty2"};
    vecs[8]  = '{1'b0, 8'b11110111, 1'b0, 5'b100_0_1, "set_line3"};
    vecs[9]  = '{1'b0, 8'b11110111, 1'b1, 5'b100_0_1, "set_dominates"};
    vecs[10] = '{1'b0, 8'hFF,       1'b1, 5'b111_1_0, "ack_line3"};
    vecs[11] = '{1'b0, 8'b11101111, 1'b0, 5'b011_0_1, "set_line4"};
    vecs[12] = '{1'b1, 8'hFF,       1'b0, 5'b111_1_1, "disable"};
    vecs[13] = '{1'b1, 8'b01111111, 1'b1, 5'b111_1_1, "disabled_ignore"};
    vecs[14] = '{1'b0, 8'hFF,       1'b0, 5'b011_0_1, "reenable_held"};
    vecs[15] = '{1'b0, 8'hFF,       1'b1, 5'b111_1_0, "ack_line4"};

    // reset, checked before any clock edge and after one edge in reset
    RST_L = 1'b0;
    EI_L  = 1'b0;
    I_L   = 8'hFF;
    ACK   = 1'b0;
    #1;
    check_now(5'b111_1_1, "reset_async");
    @(posedge CLK);
    #1;
    check_now(5'b111_1_1, "reset_held");
    @(negedge CLK);
    RST_L = 1'b1;

    // table-driven vectors
    for (int k = 0; k < 16; k++) begin
      step(vecs[k].ei_l, vecs[k].i_l, vecs[k].ack, vecs[k].exp, vecs[k].name);
    end

    // asynchronous reset mid-cycle with every line pending
    step(1'b0, 8'h00, 1'b0, 5'b000_0_1, "fill_all");
    I_L = 8'b01111111;
    #2;
    RST_L = 1'b0;
    #1;
    check_now(5'b111_1_1, "midcycle_reset");
    @(posedge CLK);
    #1;
    check_now(5'b111_1_1, "reset_edge_held");
    @(negedge CLK);
    RST_L = 1'b1;
    step(1'b0, 8'b01111111, 1'b0, 5'b111_1_0, "post_reset_edge1");
    step(1'b0, 8'b01111111, 1'b0, 5'b000_0_1, "post_reset_edge2");

    // random phase against the bench model (state known: PEND=0x80, EN=1)
    m_pend = 8'h80;
    m_en   = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic       r_ei;
      logic [7:0] r_i;
      logic       r_ack;
      logic [7:0] clr;
      logic [4:0] cur;
      r_ei  = ($urandom_range(0, 7) == 0);
      r_i   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
      r_ack = ($urandom_range(0, 1) == 1);
      cur   = model_out(m_pend, m_en);
      clr   = 8'h00;
      if (r_ack && m_en && (cur[1] == 1'b0)) clr[~cur[4:2]] = 1'b1;
      if (m_en) m_pend = (m_pend & ~clr) | ~r_i;
      m_en = ~r_ei;
      step(r_ei, r_i, r_ack, model_out(m_pend, m_en), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
